// File: rtl/patch_sched_pkg.sv
// Shared types and width helpers for the patch stream scheduler.
// Optional perf counters are enabled with PATCH_SCHED_PERF_EN.
package patch_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int TAG_IDX_W = 16;

    typedef struct packed {
        logic [TAG_IDX_W-1:0] patch_idx;
        logic [TAG_IDX_W-1:0] pos_idx;
        logic                 last_patch_beat;
        logic                 last;
    } beat_tag_t;

    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

    function automatic int total_patches(input int w, input int h, input int p);
        return (w / p) * (h / p);
    endfunction

    function automatic int patch_idx_w(input int w, input int h, input int p);
        return clog2_min1(total_patches(w, h, p));
    endfunction

    function automatic int pos_idx_w(input int p);
        return clog2_min1(p * p);
    endfunction

endpackage

// File: rtl/patch_stream_scheduler_addr_gen.sv
// Patch-major address walker: pixel column, pixel row, patch column, patch row.
// Produces the raster address and the beat tag for the current position.
module patch_addr_gen
    import patch_sched_pkg::*;
#(
    parameter int IMG_WIDTH  = 16,
    parameter int IMG_HEIGHT = 16,
    parameter int PATCH_SIZE = 4,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  advance,
    output logic [ADDR_WIDTH-1:0] addr,
    output beat_tag_t             tag,
    output logic                  last
);

    localparam int PX   = IMG_WIDTH / PATCH_SIZE;
    localparam int PY   = IMG_HEIGHT / PATCH_SIZE;
    localparam int PW   = clog2_min1(PATCH_SIZE);
    localparam int CW_X = clog2_min1(PX);
    localparam int CW_Y = clog2_min1(PY);
    localparam int PIW  = patch_idx_w(IMG_WIDTH, IMG_HEIGHT, PATCH_SIZE);
    localparam int QW   = pos_idx_w(PATCH_SIZE);

    logic [CW_Y-1:0] pr;
    logic [CW_X-1:0] pc;
    logic [PW-1:0]   r;
    logic [PW-1:0]   c;
    logic            c_wrap;
    logic            r_wrap;
    logic            pc_wrap;
    logic            pr_wrap;
    logic [PIW-1:0]  patch_idx;
    logic [QW-1:0]   pos_idx;

    assign c_wrap  = (c == PW'(PATCH_SIZE - 1));
    assign r_wrap  = (r == PW'(PATCH_SIZE - 1));
    assign pc_wrap = (pc == CW_X'(PX - 1));
    assign pr_wrap = (pr == CW_Y'(PY - 1));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            pr <= '0;
            pc <= '0;
            r  <= '0;
            c  <= '0;
        end else if (advance) begin
            c <= c_wrap ? '0 : c + 1'b1;
            if (c_wrap) begin
                r <= r_wrap ? '0 : r + 1'b1;
                if (r_wrap) begin
                    pc <= pc_wrap ? '0 : pc + 1'b1;
                    if (pc_wrap) begin
                        pr <= pr_wrap ? '0 : pr + 1'b1;
                    end
                end
            end
        end
    end

    assign addr = (ADDR_WIDTH'(pr) * ADDR_WIDTH'(PATCH_SIZE) + ADDR_WIDTH'(r))
                  * ADDR_WIDTH'(IMG_WIDTH)
                  + ADDR_WIDTH'(pc) * ADDR_WIDTH'(PATCH_SIZE)
                  + ADDR_WIDTH'(c);

    assign patch_idx = PIW'(pr) * PIW'(PX) + PIW'(pc);
    assign pos_idx   = QW'(r) * QW'(PATCH_SIZE) + QW'(c);
    assign last      = pr_wrap && pc_wrap && r_wrap && c_wrap;

    always_comb begin
        tag                 = '0;
        tag.patch_idx       = TAG_IDX_W'(patch_idx);
        tag.pos_idx         = TAG_IDX_W'(pos_idx);
        tag.last_patch_beat = r_wrap && c_wrap;
        tag.last            = last;
    end

endmodule

// File: rtl/patch_stream_scheduler.sv
// Patch-major streamer: credit-paced SRAM reads into a small output FIFO.
// Define PATCH_SCHED_PERF_EN to add stall_cycles/frame_cycles counters.
module patch_stream_scheduler
    import patch_sched_pkg::*;
#(
    parameter int PIXEL_WIDTH = 24,
    parameter int IMG_WIDTH   = 16,
    parameter int IMG_HEIGHT  = 16,
    parameter int PATCH_SIZE  = 4,
    parameter int RD_LATENCY  = 1,
    parameter int ADDR_WIDTH  = $clog2(IMG_WIDTH * IMG_HEIGHT),
    localparam int PATCH_IDX_W = patch_idx_w(IMG_WIDTH, IMG_HEIGHT, PATCH_SIZE),
    localparam int POS_IDX_W   = pos_idx_w(PATCH_SIZE)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    input  logic                   done_ack,
    output logic                   mem_rd_en,
    output logic [ADDR_WIDTH-1:0]  mem_rd_addr,
    input  logic [PIXEL_WIDTH-1:0] mem_rd_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PIXEL_WIDTH-1:0] out_data,
    output logic [PATCH_IDX_W-1:0] out_patch_idx,
    output logic [POS_IDX_W-1:0]   out_pos_idx,
    output logic                   out_last_patch_beat,
    output logic                   out_last
`ifdef PATCH_SCHED_PERF_EN
   ,output logic [31:0]            stall_cycles
   ,output logic [31:0]            frame_cycles
`endif
);

    if ((IMG_WIDTH % PATCH_SIZE) != 0 || (IMG_HEIGHT % PATCH_SIZE) != 0
        || !is_pow2(PATCH_SIZE)) begin : g_bad_geometry
        $error("patch_stream_scheduler: bad image/patch geometry");
    end

    if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
        $error("patch_stream_scheduler: RD_LATENCY must be 1..4");
    end

    localparam int D     = RD_LATENCY + 1;
    localparam int PTR_W = clog2_min1(D);
    localparam int CNT_W = $clog2(D + 1) + 1;

    state_t state;
    state_t state_nxt;

    logic                  start_acc;
    logic                  issue;
    logic                  pop;
    logic                  wr;
    logic                  credit_ok;
    logic                  ag_last;
    logic [ADDR_WIDTH-1:0] ag_addr;
    beat_tag_t             ag_tag;

    logic [RD_LATENCY-1:0] pipe_vld;
    beat_tag_t             pipe_tag [RD_LATENCY];

    logic [PIXEL_WIDTH-1:0] fifo_data [D];
    beat_tag_t              fifo_tag  [D];
    logic [PTR_W-1:0]       wptr;
    logic [PTR_W-1:0]       rptr;
    logic [CNT_W-1:0]       fifo_cnt;
    logic [CNT_W-1:0]       inflight;
    beat_tag_t              head_tag;
    logic                   unused_tag_bits;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(D - 1)) ? '0 : p + 1'b1;
    endfunction

    patch_addr_gen #(
        .IMG_WIDTH  (IMG_WIDTH),
        .IMG_HEIGHT (IMG_HEIGHT),
        .PATCH_SIZE (PATCH_SIZE),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_gen (
        .clk     (clk),
        .reset   (reset),
        .clear   (start_acc),
        .advance (issue),
        .addr    (ag_addr),
        .tag     (ag_tag),
        .last    (ag_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (issue && ag_last) state_nxt = DRAIN;
            DRAIN:   if (pop && head_tag.last) state_nxt = DONE;
            DONE:    if (done_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state)
            RUN, DRAIN: busy = 1'b1;
            DONE:       done = 1'b1;
            default:    ;
        endcase
    end

    assign start_acc = (state == IDLE) && start;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + CNT_W'(pipe_vld[i]);
        end
    end

    // A beat leaving this cycle frees its slot, keeping one beat per cycle.
    assign credit_ok   = (inflight + fifo_cnt) < (CNT_W'(D) + CNT_W'(pop));
    assign issue       = (state == RUN) && credit_ok;
    assign mem_rd_en   = issue;
    assign mem_rd_addr = ag_addr;

    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_vld <= '0;
        end else begin
            pipe_vld[0] <= issue;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        pipe_tag[0] <= ag_tag;
        for (int i = 1; i < RD_LATENCY; i++) begin
            pipe_tag[i] <= pipe_tag[i-1];
        end
    end

    assign wr = pipe_vld[RD_LATENCY-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr     <= '0;
            rptr     <= '0;
            fifo_cnt <= '0;
        end else begin
            if (wr) begin
                wptr <= ptr_inc(wptr);
            end
            if (pop) begin
                rptr <= ptr_inc(rptr);
            end
            fifo_cnt <= fifo_cnt + CNT_W'(wr) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (wr) begin
            fifo_data[wptr] <= mem_rd_data;
            fifo_tag[wptr]  <= pipe_tag[RD_LATENCY-1];
        end
    end

    assign out_valid = (fifo_cnt != '0);
    assign pop       = out_valid && out_ready;
    assign head_tag  = fifo_tag[rptr];

    // Gate with valid so an empty FIFO presents all-zero fields.
    assign out_data            = out_valid ? fifo_data[rptr] : '0;
    assign out_patch_idx       = out_valid ? head_tag.patch_idx[PATCH_IDX_W-1:0] : '0;
    assign out_pos_idx         = out_valid ? head_tag.pos_idx[POS_IDX_W-1:0] : '0;
    assign out_last_patch_beat = out_valid && head_tag.last_patch_beat;
    assign out_last            = out_valid && head_tag.last;
    assign unused_tag_bits     = ^{head_tag.patch_idx, head_tag.pos_idx};

`ifdef PATCH_SCHED_PERF_EN
    always_ff @(posedge clk) begin
        if (reset || start_acc) begin
            stall_cycles <= '0;
            frame_cycles <= '0;
        end else if (busy) begin
            frame_cycles <= frame_cycles + 32'd1;
            if (out_valid && !out_ready) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_patch_stream_scheduler.sv
// Scoreboard bench for patch_stream_scheduler (default and 8x8/P2/L3 builds).
// Perf counter checks are compiled in with PATCH_SCHED_PERF_EN.
module tb_patch_stream_scheduler;

    localparam int W  = 16;
    localparam int H  = 16;
    localparam int P  = 4;
    localparam int L  = 1;
    localparam int N  = W * H;
    localparam int SW = 8;
    localparam int SH = 8;
    localparam int SP = 2;
    localparam int SL = 3;
    localparam int SN = SW * SH;

    typedef logic [57:0] beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        reset, start, done_ack, out_ready;
    logic        busy, done, mem_rd_en, out_valid, out_lpb, out_last;
    logic [7:0]  mem_rd_addr;
    logic [23:0] mem_rd_data, out_data;
    logic [3:0]  out_patch_idx, out_pos_idx;

    logic        s_start, s_done_ack, s_out_ready;
    logic        s_busy, s_done, s_rd_en, s_valid, s_lpb, s_last;
    logic [5:0]  s_addr;
    logic [23:0] s_rdata, s_data;
    logic [3:0]  s_patch;
    logic [1:0]  s_pos;

`ifdef PATCH_SCHED_PERF_EN
    logic [31:0] stall_cycles, frame_cycles, s_stall, s_frame;
`endif

    patch_stream_scheduler u_dut (
        .clk                 (clk),
        .reset               (reset),
        .start               (start),
        .busy                (busy),
        .done                (done),
        .done_ack            (done_ack),
        .mem_rd_en           (mem_rd_en),
        .mem_rd_addr         (mem_rd_addr),
        .mem_rd_data         (mem_rd_data),
        .out_valid           (out_valid),
        .out_ready           (out_ready),
        .out_data            (out_data),
        .out_patch_idx       (out_patch_idx),
        .out_pos_idx         (out_pos_idx),
        .out_last_patch_beat (out_lpb),
        .out_last            (out_last)
`ifdef PATCH_SCHED_PERF_EN
       ,.stall_cycles        (stall_cycles)
       ,.frame_cycles        (frame_cycles)
`endif
    );

    patch_stream_scheduler #(
        .IMG_WIDTH  (SW),
        .IMG_HEIGHT (SH),
        .PATCH_SIZE (SP),
        .RD_LATENCY (SL)
    ) u_small (
        .clk                 (clk),
        .reset               (reset),
        .start               (s_start),
        .busy                (s_busy),
        .done                (s_done),
        .done_ack            (s_done_ack),
        .mem_rd_en           (s_rd_en),
        .mem_rd_addr         (s_addr),
        .mem_rd_data         (s_rdata),
        .out_valid           (s_valid),
        .out_ready           (s_out_ready),
        .out_data            (s_data),
        .out_patch_idx       (s_patch),
        .out_pos_idx         (s_pos),
        .out_last_patch_beat (s_lpb),
        .out_last            (s_last)
`ifdef PATCH_SCHED_PERF_EN
       ,.stall_cycles        (s_stall)
       ,.frame_cycles        (s_frame)
`endif
    );

    function automatic logic [23:0] pix(input int a);
        return {8'(a), 8'(a * 3 + 7), 8'(~a)};
    endfunction

    function automatic int exp_addr(input int k, input int w, input int p);
        int patch, pos, px;
        patch = k / (p * p);
        pos   = k % (p * p);
        px    = w / p;
        return ((patch / px) * p + pos / p) * w + (patch % px) * p + pos % p;
    endfunction

    function automatic beat_t exp_beat(input int k, input int w, input int h,
                                       input int p);
        int pp;
        pp = p * p;
        return {pix(exp_addr(k, w, p)), 16'(k / pp), 16'(k % pp),
                (k % pp) == pp - 1, k == w * h - 1};
    endfunction

    // SRAM models: fixed-latency registered read of pix(addr)
    logic [23:0] mq [L];
    logic [23:0] smq [SL];
    always @(posedge clk) begin
        mq[0] <= pix(int'(mem_rd_addr));
        for (int i = 1; i < L; i++) mq[i] <= mq[i-1];
        smq[0] <= pix(int'(s_addr));
        for (int i = 1; i < SL; i++) smq[i] <= smq[i-1];
    end
    assign mem_rd_data = mq[L-1];
    assign s_rdata     = smq[SL-1];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    beat_t obs, s_obs, held;
    assign obs   = {out_data, 16'(out_patch_idx), 16'(out_pos_idx), out_lpb, out_last};
    assign s_obs = {s_data, 16'(s_patch), 16'(s_pos), s_lpb, s_last};

    beat_t q[$];
    beat_t sq[$];
    int rd_cnt, issued, beats, first_v, done_c, busy_cnt, st_cyc;
    int s_rd_cnt, s_beats, s_first_v, s_done_c, s_st, s_addr4;
    logic [7:0] last_tags;
    bit pv, prdy;

    always @(negedge clk) begin
        if (reset) begin
            pv = 1'b0;
        end else begin
            if (busy) busy_cnt++;
            if (mem_rd_en) begin
                chk("rd_addr", mem_rd_addr, exp_addr(rd_cnt, W, P));
                rd_cnt++;
                issued++;
            end
            if (out_valid && first_v < 0) first_v = cyc - st_cyc;
            if (out_valid && pv && !prdy) chk("stall_hold", obs, held);
            if (out_valid && out_ready) begin
                if (q.size() == 0) chk("sb_empty", q.size(), 1);
                else chk("beat", obs, q.pop_front());
                beats++;
                if (out_last) last_tags = {out_patch_idx, out_pos_idx};
            end
            if (mem_rd_en) chk("inflight_le_D", (issued - beats) <= L + 1, 1);
            if (done && done_c < 0) done_c = cyc - st_cyc;
            pv   = out_valid;
            prdy = out_ready;
            held = obs;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (s_rd_en) begin
                chk("s_rd_addr", s_addr, exp_addr(s_rd_cnt, SW, SP));
                if (s_rd_cnt == 4) s_addr4 = int'(s_addr);
                s_rd_cnt++;
            end
            if (s_valid && s_first_v < 0) s_first_v = cyc - s_st;
            if (s_valid && s_out_ready) begin
                if (sq.size() == 0) chk("s_sb_empty", sq.size(), 1);
                else chk("s_beat", s_obs, sq.pop_front());
                s_beats++;
            end
            if (s_done && s_done_c < 0) s_done_c = cyc - s_st;
        end
    end

    task automatic start_frame();
        @(posedge clk); #1;
        q.delete();
        for (int k = 0; k < N; k++) q.push_back(exp_beat(k, W, H, P));
        rd_cnt = 0; issued = 0; beats = 0; busy_cnt = 0;
        first_v = -1; done_c = -1; last_tags = '0;
        st_cyc = cyc;
        start = 1'b1;
    endtask

    // mode 0: always ready; 1: 1,0,0,1 pattern then random; 2: 20-cycle stall
    task automatic run(input int mode, input int pulse_at, input int stop_beat);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk); #1;
            start = (i == pulse_at);
            case (mode)
                1:       out_ready = (i < 40) ? ((i % 4) == 0 || (i % 4) == 3)
                                              : 1'($urandom_range(0, 1));
                2:       out_ready = !(i >= 30 && i < 50);
                default: out_ready = 1'b1;
            endcase
            if (done || (stop_beat >= 0 && beats >= stop_beat)) begin
                ok = 1'b1;
                break;
            end
        end
        chk("run_within_budget", ok, 1);
        @(negedge clk); #1;
    endtask

    task automatic ack();
        @(posedge clk); #1;
        out_ready = 1'b1;
        done_ack  = 1'b1;
        @(posedge clk); #1;
        done_ack  = 1'b0;
    endtask

    task automatic chk_frame(input string tag);
        chk({tag, "_beats"}, beats, N);
        chk({tag, "_reads"}, rd_cnt, N);
        chk({tag, "_sb_left"}, q.size(), 0);
        chk({tag, "_last_tags"}, last_tags, 8'hff);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; done_ack = 1'b0; out_ready = 1'b0;
        s_start = 1'b0; s_done_ack = 1'b0; s_out_ready = 1'b1;
        s_rd_cnt = 0; s_beats = 0; s_first_v = -1; s_done_c = -1; s_addr4 = -1;
        s_st = 0;
        rd_cnt = 0; issued = 0; beats = 0; busy_cnt = 0;
        first_v = -1; done_c = -1; st_cyc = 0; last_tags = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", {busy, done, mem_rd_en, out_valid, out_lpb, out_last,
                           out_data, out_patch_idx, out_pos_idx, mem_rd_addr}, 0);
        reset = 1'b0;

        // Frame A: full-rate, start pulsed mid-RUN
        start_frame();
        run(0, 50, -1);
        chk("a_first_valid_cyc", first_v, 3);
        chk("a_done_cyc", done_c, 259);
        chk_frame("a");

        // DONE holds through a start pulse until acknowledged
        for (int j = 0; j < 10; j++) begin
            @(posedge clk); #1;
            start = (j == 3);
            @(negedge clk); #1;
            chk("done_hold", {done, busy}, 2'b10);
        end
        ack();
        chk("idle_after_ack", {done, busy, mem_rd_en}, 0);

        // Frame B: stalling downstream
        start_frame();
        run(1, -1, -1);
        chk_frame("b");
        ack();

        // Reset at beat 100, then a clean frame
        start_frame();
        run(0, -1, 100);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midreset_outs", {busy, done, mem_rd_en, out_valid, out_lpb, out_last,
                              out_data, out_patch_idx, out_pos_idx, mem_rd_addr}, 0);
        reset = 1'b0;
        start_frame();
        run(0, -1, -1);
        chk("c_first_valid_cyc", first_v, 3);
        chk("c_done_cyc", done_c, 259);
        chk_frame("c");
        ack();

        // Frame with a 20-cycle downstream stall
        start_frame();
        run(2, -1, -1);
        chk("d_done_cyc", done_c, 279);
        chk_frame("d");
`ifdef PATCH_SCHED_PERF_EN
        chk("stall_cycles", stall_cycles, 20);
        chk("frame_cycles_span", frame_cycles, busy_cnt);
        chk("frame_cycles_abs", frame_cycles, 278);
`endif
        ack();

        // Small geometry, RD_LATENCY=3
        @(posedge clk); #1;
        for (int k = 0; k < SN; k++) sq.push_back(exp_beat(k, SW, SH, SP));
        s_st = cyc;
        s_start = 1'b1;
        begin
            bit ok;
            ok = 1'b0;
            for (int i = 0; i < 1000; i++) begin
                @(posedge clk); #1;
                s_start = 1'b0;
                if (s_done) begin
                    ok = 1'b1;
                    break;
                end
            end
            chk("s_run_within_budget", ok, 1);
        end
        @(negedge clk); #1;
        chk("s_first_valid_cyc", s_first_v, 5);
        chk("s_done_cyc", s_done_c, 69);
        chk("s_beats", s_beats, SN);
        chk("s_sb_left", sq.size(), 0);
        chk("s_patch1_addr", s_addr4, 2);
        @(posedge clk); #1;
        s_done_ack = 1'b1;
        @(posedge clk); #1;
        s_done_ack = 1'b0;
        chk("s_idle_after_ack", {s_done, s_busy}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
